// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - access size encodings (byte / half / word; 2'b11 is handled as word)
//   - FSM state enum
//   - is_misaligned(): natural-alignment check for an access size and offset
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // size is expected already normalised (reserved 2'b11 folded to word)
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational little-endian lane logic, used by both the
// load path and the sub-word store read-modify-write path.
//   extract: ext_word/ext_off/ext_size/ext_unsigned -> ext_data
//            (byte/half lane pulled out, sign- or zero-extended; word passes)
//   merge:   mrg_old/mrg_new/mrg_off/mrg_size -> mrg_word
//            (low byte/half of mrg_new dropped into its lane of mrg_old)
// Offsets are expected pre-aligned for the size (half uses off[1] only).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] ext_word,
    input  logic [1:0]  ext_off,
    input  logic [1:0]  ext_size,
    input  logic        ext_unsigned,
    output logic [31:0] ext_data,
    input  logic [31:0] mrg_old,
    input  logic [31:0] mrg_new,
    input  logic [1:0]  mrg_off,
    input  logic [1:0]  mrg_size,
    output logic [31:0] mrg_word
);

    logic [7:0]  ext_b;
    logic [15:0] ext_h;

    assign ext_b = ext_word[{ext_off, 3'b000} +: 8];
    assign ext_h = ext_word[{ext_off[1], 4'b0000} +: 16];

    always_comb begin
        case (ext_size)
            SZ_BYTE: ext_data = {{24{ext_b[7] & ~ext_unsigned}}, ext_b};
            SZ_HALF: ext_data = {{16{ext_h[15] & ~ext_unsigned}}, ext_h};
            default: ext_data = ext_word;
        endcase
    end

    always_comb begin
        mrg_word = mrg_old;
        case (mrg_size)
            SZ_BYTE: mrg_word[{mrg_off, 3'b000} +: 8]     = mrg_new[7:0];
            SZ_HALF: mrg_word[{mrg_off[1], 4'b0000} +: 16] = mrg_new[15:0];
            default: mrg_word = mrg_new;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: core-side initiator for a word-organised data memory.
//   Core side : req_valid/req_ready handshake, req_write, req_size,
//               req_unsigned, req_addr, req_wdata; resp_valid pulse with
//               resp_rdata (extended load data, 0 for stores).
//   Memory    : mem_addr (word aligned), mem_wdata, mem_write, mem_rdata
//               (combinational read of mem_addr).
// Flow: load IDLE->RD->DONE, word store IDLE->WR->DONE, sub-word store
// IDLE->RD->WR->DONE (read-modify-write).
// Optional macro LSU_MISALIGN_TRAP_EN: adds output misalign; misaligned
// requests skip memory and complete at once with misalign=1, rdata=0.
// Without it the offending low address bits are dropped and the access
// proceeds aligned.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              misalign
`endif
);

    lsu_state_t        state;
    logic              c_write;
    logic              c_uns;
    logic [1:0]        c_size;
    logic [1:0]        c_off;
    logic [DATA_W-1:0] c_wdata;

    logic [1:0]        n_size;
    logic [1:0]        n_off;
    logic              trap;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] mrg_word;

    // Outputs are decodes of the state register, so mem_write and
    // resp_valid fall as soon as the async reset hits the state.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign mem_write  = (state == WR);

    assign n_size = (req_size == 2'b11) ? SZ_WORD : req_size;

    // Lane offset with disallowed low bits already cleared, so the
    // untrapped misaligned case simply behaves as the aligned access.
    always_comb begin
        case (n_size)
            SZ_BYTE: n_off = req_addr[1:0];
            SZ_HALF: n_off = {req_addr[1], 1'b0};
            default: n_off = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = is_misaligned(n_size, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    lsu_lane_align u_align (
        .ext_word     (mem_rdata),
        .ext_off      (c_off),
        .ext_size     (c_size),
        .ext_unsigned (c_uns),
        .ext_data     (ext_data),
        .mrg_old      (mem_rdata),
        .mrg_new      (c_wdata),
        .mrg_off      (c_off),
        .mrg_size     (c_size),
        .mrg_word     (mrg_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            c_write    <= 1'b0;
            c_uns      <= 1'b0;
            c_size     <= SZ_BYTE;
            c_off      <= 2'b00;
            c_wdata    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        c_write <= req_write;
                        c_uns   <= req_unsigned;
                        c_size  <= n_size;
                        c_off   <= n_off;
                        c_wdata <= req_wdata;
                        if (trap) begin
                            resp_rdata <= '0;
                            state      <= DONE;
                        end else begin
                            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (req_write && n_size == SZ_WORD) begin
                                mem_wdata <= req_wdata;
                                state     <= WR;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    if (c_write) begin
                        mem_wdata <= mrg_word;
                        state     <= WR;
                    end else begin
                        resp_rdata <= ext_data;
                        state      <= DONE;
                    end
                end
                WR: begin
                    resp_rdata <= '0;
                    state      <= DONE;
                end
                DONE: state <= IDLE;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Raised at accept for a trapped request, visible only in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign <= 1'b0;
        else if (state == IDLE && req_valid)
            misalign <= trap;
        else if (state == DONE)
            misalign <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus randomized test of load_store_unit
// against a byte-array reference model of memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic [31:0] mem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
    logic        exp_mis;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] mem  [0:1023];
    logic [7:0]  refb [0:4095];
    logic        pre_we   = 1'b0;
    logic [31:0] pre_addr = '0;
    logic [31:0] pre_data = '0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign     (misalign)
`endif
    );

    // Data memory: combinational read, write on posedge; pre_we loads
    // initial contents while the unit is idle.
    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_write)   mem[mem_addr[11:2]] <= mem_wdata;
        else if (pre_we) mem[pre_addr[11:2]] <= pre_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a - (a % 4);
        return {refb[b+3], refb[b+2], refb[b+1], refb[b]};
    endfunction

    task automatic preset(input logic [31:0] a, input logic [31:0] w);
        int b;
        pre_we = 1'b1; pre_addr = a; pre_data = w;
        @(negedge clk);
        pre_we = 1'b0;
        b = int'(a[11:0]) & ~3;
        for (int i = 0; i < 4; i++) refb[b+i] = w[8*i +: 8];
    endtask

    // Reference: an access of n bytes starting at the size-aligned address.
    task automatic model(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int nwr,
                         output logic [31:0] waddr, output logic [31:0] wword,
                         output logic [31:0] rdata);
        int n;
        int base;
        logic [31:0] v;
        logic skip;
        n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base  = int'(a[11:0]);
        base  = base - (base % n);
        waddr = {a[31:2], 2'b00};
        wword = '0;
        rdata = '0;
        skip  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        exp_mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        skip    = exp_mis;
`endif
        if (skip) begin
            lat = 1;
            nwr = 0;
        end else if (w) begin
            for (int i = 0; i < n; i++) refb[base+i] = d[8*i +: 8];
            wword = ref_word(base);
            lat   = (n < 4) ? 3 : 2;
            nwr   = 1;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(refb[base+i]) << (8*i));
            if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            rdata = v;
            lat   = 2;
            nwr   = 0;
        end
    endtask

    // Called just after a negedge; returns 1 ns after the accepting edge
    // with the request fields scrambled to prove they were captured.
    task automatic start_req(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] d);
        int n;
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_write    = 1'($urandom_range(0, 1));
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));
        req_addr     = $urandom;
        req_wdata    = $urandom;
    endtask

    task automatic finish_req(input int elat, input int enwr, input logic [31:0] ewaddr,
                              input logic [31:0] ewword, input logic [31:0] erdata,
                              output logic [31:0] got);
        int n;
        int nwr;
        logic done;
        logic [31:0] wa;
        logic [31:0] wd;
`ifdef LSU_MISALIGN_TRAP_EN
        logic mis_seen;
        mis_seen = 1'b0;
`endif
        n = 0; nwr = 0; done = 1'b0; wa = '0; wd = '0; got = '0;
        while (!done && n < 8) begin
            @(negedge clk);
            n++;
            if (mem_write) begin
                nwr++;
                wa = mem_addr;
                wd = mem_wdata;
            end
            if (resp_valid) begin
                done = 1'b1;
                got  = resp_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
                mis_seen = misalign;
`endif
            end else begin
                chk("busy_ready", 32'(req_ready), 0);
            end
        end
        chk("latency", n, elat);
        chk("mem_write_cycles", nwr, enwr);
        chk("resp_rdata", got, erdata);
        if (enwr != 0) begin
            chk("mem_addr", wa, ewaddr);
            chk("mem_wdata", wd, ewword);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        chk("misalign", 32'(mis_seen), 32'(exp_mis));
`endif
        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid), 0);
        chk("ready_after", 32'(req_ready), 1);
    endtask

    task automatic txn(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
        int lat;
        int nwr;
        logic [31:0] wa, ww, rd;
        model(w, sz, u, a, d, lat, nwr, wa, ww, rd);
        start_req(w, sz, u, a, d);
        finish_req(lat, nwr, wa, ww, rd, got);
    endtask

    initial begin
        logic [31:0] got;
        int lat;
        int nwr;
        logic [31:0] wa, ww, rd;
        logic w, u;
        logic [1:0] sz;

        for (int i = 0; i < 4096; i++) refb[i] = 8'h00;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 64; i++) preset(32'(i*4), $urandom);

        // Word load
        preset(32'h7D0, 32'h1122_3344);
        txn(0, 2'b10, 0, 32'h7D0, 0, got);
        chk("lw_7d0", got, 32'h1122_3344);

        // Sub-word loads and extension
        preset(32'h7D4, 32'h0000_80F0);
        txn(0, 2'b00, 0, 32'h7D4, 0, got);  chk("lb_7d4", got, 32'hFFFF_FFF0);
        txn(0, 2'b00, 1, 32'h7D4, 0, got);  chk("lbu_7d4", got, 32'h0000_00F0);
        txn(0, 2'b01, 0, 32'h7D4, 0, got);  chk("lh_7d4", got, 32'hFFFF_80F0);
        txn(0, 2'b00, 1, 32'h7D5, 0, got);  chk("lbu_7d5", got, 32'h0000_0080);

        // Reset while a byte store sits in RD: nothing may be written
        preset(32'h7D8, 32'hAABB_CCDD);
        start_req(1, 2'b00, 0, 32'h7DA, 32'h55);
        rst = 1'b1;
        #1;
        chk("midrst_mem_write", 32'(mem_write), 0);
        chk("midrst_ready", 32'(req_ready), 1);
        chk("midrst_resp_valid", 32'(resp_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_mem_kept", mem[32'h7D8 >> 2], 32'hAABB_CCDD);
        chk("midrst_no_resp", 32'(resp_valid), 0);

        // Byte store read-modify-write, then read back
        txn(1, 2'b00, 0, 32'h7DA, 32'h55, got);
        txn(0, 2'b10, 0, 32'h7D8, 0, got);
        chk("lw_after_sb", got, 32'hAA55_CCDD);

        // Back-to-back: the load is held valid throughout the halfword store
        preset(32'h7DC, 32'h0);
        model(1, 2'b01, 0, 32'h7DE, 32'h1234, lat, nwr, wa, ww, rd);
        start_req(1, 2'b01, 0, 32'h7DE, 32'h1234);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h7DC; req_wdata = '0;
        finish_req(lat, nwr, wa, ww, rd, got);
        model(0, 2'b10, 0, 32'h7DC, 0, lat, nwr, wa, ww, rd);
        start_req(0, 2'b10, 0, 32'h7DC, 0);
        finish_req(lat, nwr, wa, ww, rd, got);
        chk("lw_after_sh", got, 32'h1234_0000);

        // Misaligned word load
        txn(0, 2'b10, 0, 32'h7D1, 0, got);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_7d1_trap", got, 32'h0);
`else
        chk("lw_7d1_aligned", got, 32'h1122_3344);
`endif

        // Randomized traffic over the first 64 words
        for (int k = 0; k < 120; k++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            txn(w, sz, u, 32'($urandom_range(0, 255)), $urandom, got);
        end

        for (int i = 0; i < 64; i++) chk("mem_sweep", mem[i], ref_word(i*4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side initiator for the word-organised data memory (word-indexed by Address[31:2], combinational read, write on posedge clk when MemWrite).
- Accepts byte/halfword/word load and store requests from the core through a valid/ready handshake.
- Drives the memory's address, write-data and write-enable.
- Implements sub-word stores as read-modify-write, and sub-word loads as lane extraction with sign or zero extension.

Parameters:
ADDR_W, 32, request/memory address width
DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  core request present
req_ready  output  1  unit can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  32  byte address
req_wdata  input  32  store data; low bits used for sub-word stores
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores
mem_addr  output  32  word-aligned address to memory; bits [1:0] always 0
mem_wdata  output  32  merged write word
mem_write  output  1  memory write enable
mem_rdata  input  32  memory read data, combinational from mem_addr

Behaviour:
- Reset state (async): FSM=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Handshake: transfer when req_valid & req_ready on a rising edge.
  - req_ready=1 only in IDLE.
  - At transfer, addr/size/unsigned/wdata/write are captured into registers; the core may change its inputs afterwards.
- FSM states: IDLE, RD, WR, DONE.
  - Load: IDLE -> RD -> DONE -> IDLE.
  - Word store: IDLE -> WR -> DONE -> IDLE.
  - Sub-word store: IDLE -> RD -> WR -> DONE -> IDLE.
- mem_addr = {captured_addr[31:2], 2'b00} in RD and WR; holds its last value elsewhere.
- mem_write is a decode of state: 1 only in WR, exactly one cycle per store.
- RD: mem_rdata is registered at the end of the cycle.
  - Load: extract lane into resp_rdata.
  - Sub-word store: merge the new lane into the read word to form mem_wdata.
- WR: mem_wdata holds req_wdata for word stores, or the merged word for sub-word stores.
- DONE: resp_valid=1 for exactly one cycle. resp_rdata is valid in the same cycle and held until the next DONE.
- Latency, accept edge to resp_valid: load 2 cycles, word store 2, sub-word store 3.
- Lane mapping (little-endian):
  - byte k (k = addr[1:0]) occupies bits [8k+7:8k];
  - halfword at addr[1]=h occupies bits [16h+15:16h].
- Extension: byte/half loads sign-extend from the top lane bit unless req_unsigned; word loads ignore req_unsigned.
- Misaligned access (half with addr[0]=1, word with addr[1:0]!=0): see Optional Feature.
- Reset mid-operation: FSM returns to IDLE immediately; mem_write drops asynchronously; any pending write or response is discarded (a store in RD never writes).
- req_valid while not ready: ignored; the core must hold it until accepted.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign (1 bit, reset 0).
  - A misaligned request goes IDLE -> DONE directly; misalign=1 together with resp_valid; resp_rdata=0.
  - No memory read or write occurs.
- Undefined:
  - No port.
  - Offending low address bits are forced to 0 (half uses addr[1], word uses aligned word) and the access proceeds normally.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state enum (IDLE, RD, WR, DONE);
  - function is_misaligned(size, addr[1:0]).
- Sub-module lsu_lane_align (combinational):
  - extract path: word, offset, size, unsigned -> extended data;
  - merge path: old word, new data, offset, size -> merged word.
  - Shared by the load and RMW paths.

Test Plan:
- Memory word 0x7D0 preset 0x11223344; lw 0x7D0 -> resp_valid 2 cycles after accept, resp_rdata=0x11223344, mem_write never asserted.
- Word 0x7D4=0x000080F0:
  - lb 0x7D4 -> 0xFFFFFFF0;
  - lbu 0x7D4 -> 0x000000F0;
  - lh 0x7D4 -> 0xFFFF80F0;
  - lbu 0x7D5 -> 0x00000080.
- Word 0x7D8=0xAABBCCDD; sb 0x7DA data 0x00000055 -> exactly one mem_write cycle with mem_addr=0x7D8, mem_wdata=0xAA55CCDD; resp_valid 3 cycles after accept; following lw reads 0xAA55CCDD.
- sh 0x7DE data 0x1234 onto 0x00000000 -> memory 0x12340000. Back-to-back requests: req_ready low in RD/WR/DONE, second request accepted only on return to IDLE.
- Assert rst during RD of an sb -> mem_write stays 0, memory unchanged, req_ready=1 and resp_valid=0 immediately after rst.
- Misaligned lw 0x7D1:
  - with LSU_MISALIGN_TRAP_EN: misalign=1 with resp_valid, no mem_write, resp_rdata=0;
  - without it: reads word at 0x7D0.
